deparser_do_deparsing: RTL and testbench
========================================

# deparser_do_deparsing

Deparser core: the write-back counterpart of the parser. It takes a finished packet header vector (PHV), the original first two packet segments and a 160-bit deparse action word, then overwrites the header bytes of the segments with PHV container contents. The result goes out under a valid/ready handshake to the output packet path. It sits at the pipeline tail, after the last match-action stage and ahead of the segment-merge/output FIFO logic.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 512, segment width in bits
- C_AXIS_TUSER_WIDTH, 128, tuser width
- C_NUM_SEGS, 2, segments per packet header window (window = 128 bytes)
- PKT_HDR_LEN, 1024, PHV width: 8×6B + 8×4B + 8×2B containers (768 b) + 256 b metadata
- C_PARSER_RAM_WIDTH, 160, deparse action word width (10 entries × 16 b)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- phv_in  in  PKT_HDR_LEN  PHV from last stage
- phv_in_valid / phv_in_ready  in / out  1  PHV handshake
- segs_in  in  C_NUM_SEGS*C_AXIS_DATA_WIDTH  original header segments
- tuser_1st_in  in  C_AXIS_TUSER_WIDTH  tuser of first segment
- segs_in_valid / segs_in_ready  in / out  1  segment handshake
- bram_in  in  C_PARSER_RAM_WIDTH  deparse action word
- bram_in_valid / bram_in_ready  in / out  1  action handshake
- segs_out  out  C_NUM_SEGS*C_AXIS_DATA_WIDTH  rewritten segments
- tuser_1st_out  out  C_AXIS_TUSER_WIDTH  tuser_1st_in passed through
- segs_out_valid  out  1  output valid
- segs_out_ready  in  1  downstream ready
- deparse_err  out  1  one-cycle pulse per rejected entry

## Operation
- Byte k of a segment window = segs[8k+7:8k], k = 0..127.
- Containers, all MSB-aligned in the PHV:
  - 6B container i at phv[PKT_HDR_LEN-1-48i -: 48].
  - 4B container i at phv[PKT_HDR_LEN-385-32i -: 32].
  - 2B container i at phv[PKT_HDR_LEN-641-16i -: 16].
  - Metadata (low 256 b) is ignored.
- Action entry e = bram[16e+15:16e], e = 0..9. Fields:
  - [15] valid
  - [14:13] type: 0 = 2B, 1 = 4B, 2 = 6B, 3 = reserved
  - [12:10] container index
  - [9:3] byte offset
  - [2:0] reserved
- Entry write: container byte 0 (the MSB) goes to segment byte offset; byte j goes to offset+j.
- Entries are applied in order 0..9. On overlap the later entry wins.
- An entry is skipped with no write when valid = 0.
- An entry is rejected (no write, deparse_err pulse) when type = 3 or offset+len > 128.
- FSM states:
  - COLLECT:
    - Each *_ready = 1 while its input is not yet captured.
    - Inputs may arrive in any order and any cycle.
    - Once all three captured flags are set, go to WRITE with idx = 0.
  - WRITE:
    - Applies entry idx to the working segment register, one entry per cycle.
    - idx counts 0..9. At idx = 9, go to EMIT.
    - All readies are 0.
  - EMIT:
    - segs_out_valid = 1. segs_out and tuser_1st_out are stable until the handshake.
    - On segs_out_valid & segs_out_ready: clear the flags, drop valid, go to COLLECT.

## Timing
- Reset values: segs_out = 0, tuser_1st_out = 0, segs_out_valid = 0, deparse_err = 0, state = COLLECT, flags = 0, idx = 0. All readies are 0 while rst = 1 and 1 in the first cycle after release.
- Latency: with the last input accepted at edge E, WRITE starts at edge E+1 and segs_out_valid rises at edge E+11.
- deparse_err is registered. It is high for the cycle after the WRITE edge that rejected the entry.
- Back-pressure: while segs_out_ready = 0, EMIT holds indefinitely and the outputs do not change.
- Readies rise the cycle after the output handshake. There is no same-cycle overlap of the output handshake and input accept.
- Simultaneous capture of all three inputs in one cycle is legal.
- A repeated valid on an already-captured input is ignored: ready is low for that input.
- rst mid-WRITE or mid-EMIT aborts the packet with no output. All state returns to reset values at the next edge.

## Structure
- Package deparser_pkg holds:
  - entry field positions and type encodings (2B/4B/6B/reserved)
  - container widths, counts and PHV base offsets
  - FSM state enum and the entry count (10)
- Sub-module deparser_entry_apply: combinational. Takes the window, the PHV and one 16-bit entry; returns the modified window plus a reject flag. The top module holds the FSM, flags, idx counter and registers.

## Test plan
- Single entry {valid, type 2, idx 0, off 0}, PHV 6B c0 = 0x112233445566, segs all 0: output bytes 0..5 = 11 22 33 44 55 66, rest 0, valid at E+11.
- Overlap, entry 0 {2B c1 = 0xAAAA, off 10} then entry 1 {2B c2 = 0xBBBB, off 11}: bytes 10, 11, 12 = AA BB BB.
- Out-of-bounds {4B, off 126} and type 3: no bytes change, deparse_err pulses twice.
- Input order: segs, then PHV 3 cycles later, then bram 5 cycles later; each ready drops after its capture and the output matches the same-cycle-arrival case.
- Hold segs_out_ready = 0 for 20 cycles in EMIT: outputs stable and readies 0; ready = 1 completes the transfer and readies return next cycle.
- Assert rst at WRITE idx = 4: no segs_out_valid; after release, a new packet deparses correctly.

Source files
------------

// File: rtl/deparser_pkg.sv
// Shared definitions for the deparser: action-entry layout, container geometry,
// FSM state encodings and the entry-length helper.
package deparser_pkg;

  // Action word layout
  localparam int ENTRY_W      = 16;
  localparam int NUM_ENTRIES  = 10;
  localparam int ENT_VALID    = 15;
  localparam int ENT_TYPE_HI  = 14;
  localparam int ENT_TYPE_LO  = 13;
  localparam int ENT_IDX_HI   = 12;
  localparam int ENT_IDX_LO   = 10;
  localparam int ENT_OFF_HI   = 9;
  localparam int ENT_OFF_LO   = 3;

  // Entry type encodings
  localparam logic [1:0] TYPE_2B   = 2'd0;
  localparam logic [1:0] TYPE_4B   = 2'd1;
  localparam logic [1:0] TYPE_6B   = 2'd2;
  localparam logic [1:0] TYPE_RSVD = 2'd3;

  // Container geometry; offsets are bit distances from the PHV MSB
  localparam int CONT_COUNT  = 8;
  localparam int C6_W        = 48;
  localparam int C4_W        = 32;
  localparam int C2_W        = 16;
  localparam int C6_TOP_OFF  = 0;
  localparam int C4_TOP_OFF  = 384;
  localparam int C2_TOP_OFF  = 640;

  // FSM states
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  // Number of bytes an entry of the given type writes
  function automatic logic [7:0] entry_len(input logic [1:0] ent_type);
    case (ent_type)
      TYPE_2B: return 8'd2;
      TYPE_4B: return 8'd4;
      TYPE_6B: return 8'd6;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/deparser_do_deparsing_if.sv
// Bus bundle of the deparser: PHV, segment and action inputs plus the
// rewritten-segment output path.
interface deparser_do_deparsing_if #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 2,
  parameter int PKT_HDR_LEN        = 1024,
  parameter int C_PARSER_RAM_WIDTH = 160
) ();

  logic [PKT_HDR_LEN-1:0]                  phv_in;
  logic                                    phv_in_valid;
  logic                                    phv_in_ready;
  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_in;
  logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st_in;
  logic                                    segs_in_valid;
  logic                                    segs_in_ready;
  logic [C_PARSER_RAM_WIDTH-1:0]           bram_in;
  logic                                    bram_in_valid;
  logic                                    bram_in_ready;
  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_out;
  logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st_out;
  logic                                    segs_out_valid;
  logic                                    segs_out_ready;
  logic                                    deparse_err;

  modport master (
    output phv_in, phv_in_valid, segs_in, tuser_1st_in, segs_in_valid,
           bram_in, bram_in_valid, segs_out_ready,
    input  phv_in_ready, segs_in_ready, bram_in_ready, segs_out,
           tuser_1st_out, segs_out_valid, deparse_err
  );

  modport slave (
    input  phv_in, phv_in_valid, segs_in, tuser_1st_in, segs_in_valid,
           bram_in, bram_in_valid, segs_out_ready,
    output phv_in_ready, segs_in_ready, bram_in_ready, segs_out,
           tuser_1st_out, segs_out_valid, deparse_err
  );

endinterface

// File: rtl/deparser_entry_apply.sv
// Applies one 16-bit deparse action entry to a header window: copies the
// selected PHV container MSB-first into the window starting at the entry's
// byte offset, or flags the entry as rejected.
module deparser_entry_apply
  import deparser_pkg::*;
#(
  parameter int PKT_HDR_LEN = 1024,
  parameter int WIN_W       = 1024
) (
  input  logic [WIN_W-1:0]       win_in,
  input  logic [PKT_HDR_LEN-1:0] phv,
  input  logic [ENTRY_W-1:0]     entry,
  output logic [WIN_W-1:0]       win_out,
  output logic                   reject
);

  localparam int NBYTES = WIN_W / 8;
  localparam int IDX_W  = $clog2(CONT_COUNT);

  logic                   ent_valid_s;
  logic [1:0]             ent_type_s;
  logic [IDX_W-1:0]       ent_idx_s;
  logic [6:0]             ent_off_s;
  logic [7:0]             ent_len_s;
  logic [7:0]             ent_end_s;
  logic [10:0]            shamt_s;
  logic [PKT_HDR_LEN-1:0] phv_sh_s;
  logic [7:0]             cbyte_s [8];
  logic                   write_s;
  logic                   unused_bits_s;

  assign ent_valid_s = entry[ENT_VALID];
  assign ent_type_s  = entry[ENT_TYPE_HI:ENT_TYPE_LO];
  assign ent_idx_s   = entry[ENT_IDX_HI:ENT_IDX_LO];
  assign ent_off_s   = entry[ENT_OFF_HI:ENT_OFF_LO];
  assign ent_len_s   = entry_len(ent_type_s);
  assign ent_end_s   = {1'b0, ent_off_s} + ent_len_s;

  // Distance of the selected container's MSB from the PHV MSB
  always_comb begin
    case (ent_type_s)
      TYPE_2B: shamt_s = 11'(C2_TOP_OFF) + 11'(ent_idx_s) * 11'(C2_W);
      TYPE_4B: shamt_s = 11'(C4_TOP_OFF) + 11'(ent_idx_s) * 11'(C4_W);
      TYPE_6B: shamt_s = 11'(C6_TOP_OFF) + 11'(ent_idx_s) * 11'(C6_W);
      default: shamt_s = 11'd0;
    endcase
  end

  // Bring the container to the top so its bytes sit at fixed positions
  assign phv_sh_s = phv << shamt_s;

  for (genvar j = 0; j < 6; j++) begin : g_cbyte
    assign cbyte_s[j] = phv_sh_s[PKT_HDR_LEN-1-8*j -: 8];
  end
  assign cbyte_s[6] = 8'h00;
  assign cbyte_s[7] = 8'h00;

  // Reserved bits and the tail of the shifted PHV never reach the window
  assign unused_bits_s = ^{entry[2:0], phv_sh_s[PKT_HDR_LEN-C6_W-1:0]};

  // Decide between skip, reject and write
  always_comb begin
    if (!ent_valid_s) begin
      write_s = 1'b0;
      reject  = 1'b0;
    end else if ((ent_type_s == TYPE_RSVD) || (ent_end_s > 8'(NBYTES))) begin
      write_s = 1'b0;
      reject  = 1'b1;
    end else begin
      write_s = 1'b1;
      reject  = 1'b0;
    end
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    logic [7:0] rel_s;
    logic       hit_s;
    assign rel_s = 8'(k) - {1'b0, ent_off_s};
    assign hit_s = write_s && (8'(k) >= {1'b0, ent_off_s}) && (8'(k) < ent_end_s);
    assign win_out[8*k +: 8] = hit_s ? cbyte_s[rel_s[2:0]] : win_in[8*k +: 8];
  end

endmodule

// File: rtl/deparser_do_deparsing.sv
// Deparser core: collects PHV, header segments and the deparse action word,
// applies the ten action entries one per cycle and emits the rewritten
// segments under a valid/ready handshake.
module deparser_do_deparsing
  import deparser_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 2,
  parameter int PKT_HDR_LEN        = 1024,
  parameter int C_PARSER_RAM_WIDTH = 160
) (
  input logic                   clk,
  input logic                   rst,
  deparser_do_deparsing_if.slave bus
);

  localparam int WIN_W = C_NUM_SEGS * C_AXIS_DATA_WIDTH;

  logic [1:0]                    state_r;
  logic [3:0]                    idx_r;
  logic                          phv_got_r;
  logic                          segs_got_r;
  logic                          bram_got_r;
  logic [PKT_HDR_LEN-1:0]        phv_r;
  logic [C_PARSER_RAM_WIDTH-1:0] bram_r;
  logic [WIN_W-1:0]              work_r;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_r;
  logic [WIN_W-1:0]              segs_out_r;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_out_r;
  logic                          valid_r;
  logic                          err_r;

  logic [ENTRY_W-1:0]            entry_s;
  logic [WIN_W-1:0]              applied_s;
  logic                          reject_s;
  logic                          all_got_s;
  logic                          collect_s;

  assign all_got_s = phv_got_r & segs_got_r & bram_got_r;
  assign collect_s = (state_r == ST_COLLECT);
  assign entry_s   = ENTRY_W'(bram_r >> {idx_r, 4'b0000});

  deparser_entry_apply #(
    .PKT_HDR_LEN (PKT_HDR_LEN),
    .WIN_W       (WIN_W)
  ) u_apply (
    .win_in  (work_r),
    .phv     (phv_r),
    .entry   (entry_s),
    .win_out (applied_s),
    .reject  (reject_s)
  );

  // Each input is offered only while collecting and not yet captured
  always_comb begin
    if (rst) begin
      bus.phv_in_ready  = 1'b0;
      bus.segs_in_ready = 1'b0;
      bus.bram_in_ready = 1'b0;
    end else begin
      bus.phv_in_ready  = collect_s & ~phv_got_r;
      bus.segs_in_ready = collect_s & ~segs_got_r;
      bus.bram_in_ready = collect_s & ~bram_got_r;
    end
  end

  assign bus.segs_out       = segs_out_r;
  assign bus.tuser_1st_out  = tuser_out_r;
  assign bus.segs_out_valid = valid_r;
  assign bus.deparse_err    = err_r;

  // Collect / write / emit sequencing with all working state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_COLLECT;
      idx_r       <= 4'd0;
      phv_got_r   <= 1'b0;
      segs_got_r  <= 1'b0;
      bram_got_r  <= 1'b0;
      phv_r       <= '0;
      bram_r      <= '0;
      work_r      <= '0;
      tuser_r     <= '0;
      segs_out_r  <= '0;
      tuser_out_r <= '0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_COLLECT: begin
          if (all_got_s) begin
            state_r <= ST_WRITE;
            idx_r   <= 4'd0;
          end else begin
            if (bus.phv_in_valid && bus.phv_in_ready) begin
              phv_r     <= bus.phv_in;
              phv_got_r <= 1'b1;
            end
            if (bus.segs_in_valid && bus.segs_in_ready) begin
              work_r     <= bus.segs_in;
              tuser_r    <= bus.tuser_1st_in;
              segs_got_r <= 1'b1;
            end
            if (bus.bram_in_valid && bus.bram_in_ready) begin
              bram_r     <= bus.bram_in;
              bram_got_r <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          work_r <= applied_s;
          err_r  <= reject_s;
          if (idx_r == 4'(NUM_ENTRIES - 1)) begin
            state_r     <= ST_EMIT;
            idx_r       <= 4'd0;
            segs_out_r  <= applied_s;
            tuser_out_r <= tuser_r;
            valid_r     <= 1'b1;
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        ST_EMIT: begin
          if (bus.segs_out_ready) begin
            valid_r    <= 1'b0;
            phv_got_r  <= 1'b0;
            segs_got_r <= 1'b0;
            bram_got_r <= 1'b0;
            state_r    <= ST_COLLECT;
          end
        end
        default: begin
          state_r <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deparser_do_deparsing.sv
// Randomized self-checking bench for deparser_do_deparsing with a byte-array
// reference model of the deparse rules.
module tb_deparser_do_deparsing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [1023:0] exp_out;
  bit            exp_rej [10];

  always #5 clk = ~clk;

  deparser_do_deparsing_if bus ();

  deparser_do_deparsing dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_ent(input int v, input int ty, input int ci, input int off, input int rsv);
    logic [15:0] e;
    e = {1'(v), 2'(ty), 3'(ci), 7'(off), 3'(rsv)};
    return e;
  endfunction

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r = (r << 32) | 1024'($urandom);
    return r;
  endfunction

  function automatic logic [159:0] rand_bram();
    logic [159:0] b;
    b = '0;
    for (int e = 0; e < 10; e++) begin
      int ty;
      ty = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      b = b | (160'(mk_ent(int'($urandom_range(0, 7) != 0), ty, int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 127)), int'($urandom_range(0, 7)))) << (16 * e));
    end
    return b;
  endfunction

  // Reference: window and PHV as byte arrays, entries applied in order
  function automatic void model(input logic [1023:0] segs, input logic [1023:0] phv, input logic [159:0] bram);
    logic [7:0] win [128];
    logic [7:0] pb [128];
    for (int k = 0; k < 128; k++) begin
      win[k] = 8'(segs >> (8 * k));
      pb[k]  = 8'(phv >> (1016 - 8 * k));
    end
    for (int e = 0; e < 10; e++) begin
      logic [15:0] ent;
      int ty, ci, off, len, base;
      ent = 16'(bram >> (16 * e));
      ty  = int'(ent[14:13]);
      ci  = int'(ent[12:10]);
      off = int'(ent[9:3]);
      exp_rej[e] = 1'b0;
      if (ent[15]) begin
        len  = (ty == 0) ? 2 : ((ty == 1) ? 4 : 6);
        base = (ty == 0) ? 80 + 2 * ci : ((ty == 1) ? 48 + 4 * ci : 6 * ci);
        if (ty == 3 || off + len > 128) exp_rej[e] = 1'b1;
        else for (int j = 0; j < len; j++) win[off + j] = pb[base + j];
      end
    end
    exp_out = '0;
    for (int k = 0; k < 128; k++) exp_out = exp_out | (1024'(win[k]) << (8 * k));
  endfunction

  // Drives one packet with per-input arrival delays; rst_at >= 1 aborts it
  task automatic run_packet(input logic [1023:0] segs, input logic [1023:0] phv, input logic [159:0] bram,
                            input logic [127:0] tuser, input int d_segs, input int d_phv, input int d_bram,
                            input int hold, input int rst_at);
    bit got_s, got_p, got_b, acc_s, acc_p, acc_b;
    int c;
    got_s = 0; got_p = 0; got_b = 0; c = 0;
    model(segs, phv, bram);
    while (!(got_s && got_p && got_b) && c < 200) begin
      @(negedge clk);
      if (got_s) begin
        check("segs_rdy_low", bus.segs_in_ready, 1'b0);
        bus.segs_in = rand_wide();
        bus.tuser_1st_in = 128'(rand_wide());
      end else begin
        check("segs_rdy_high", bus.segs_in_ready, 1'b1);
        if (c >= d_segs) begin
          bus.segs_in_valid = 1'b1; bus.segs_in = segs; bus.tuser_1st_in = tuser;
        end
      end
      if (got_p) begin
        check("phv_rdy_low", bus.phv_in_ready, 1'b0);
        bus.phv_in = rand_wide();
      end else begin
        check("phv_rdy_high", bus.phv_in_ready, 1'b1);
        if (c >= d_phv) begin
          bus.phv_in_valid = 1'b1; bus.phv_in = phv;
        end
      end
      if (got_b) begin
        check("bram_rdy_low", bus.bram_in_ready, 1'b0);
        bus.bram_in = rand_bram();
      end else begin
        check("bram_rdy_high", bus.bram_in_ready, 1'b1);
        if (c >= d_bram) begin
          bus.bram_in_valid = 1'b1; bus.bram_in = bram;
        end
      end
      acc_s = !got_s && bus.segs_in_valid && bus.segs_in_ready;
      acc_p = !got_p && bus.phv_in_valid && bus.phv_in_ready;
      acc_b = !got_b && bus.bram_in_valid && bus.bram_in_ready;
      got_s = got_s | acc_s; got_p = got_p | acc_p; got_b = got_b | acc_b;
      c++;
    end
    if (!(got_s && got_p && got_b)) begin
      check("accept_timeout", 1'b0, 1'b1);
      bus.segs_in_valid = 1'b0; bus.phv_in_valid = 1'b0; bus.bram_in_valid = 1'b0;
      return;
    end
    // Cycle after the last accept edge
    @(negedge clk);
    bus.segs_in_valid = 1'b0; bus.phv_in_valid = 1'b0; bus.bram_in_valid = 1'b0;
    check("rdy_all_got", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b000);
    check("valid_n0", bus.segs_out_valid, 1'b0);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      check("valid_lat", bus.segs_out_valid, (n == 11) ? 1'b1 : 1'b0);
      check("err", bus.deparse_err, (n >= 2) ? exp_rej[n - 2] : 1'b0);
      check("rdy_busy", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b000);
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check("rdy_in_rst", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b000);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("abort_valid", bus.segs_out_valid, 1'b0);
          check("abort_err", bus.deparse_err, 1'b0);
          check("abort_segs_lo", bus.segs_out[511:0], 512'd0);
          check("abort_tuser", bus.tuser_1st_out, 128'd0);
        end
        rst = 1'b0;
        #1;
        check("rdy_release", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b111);
        return;
      end
    end
    check("out_lo", bus.segs_out[511:0], exp_out[511:0]);
    check("out_hi", bus.segs_out[1023:512], exp_out[1023:512]);
    check("tuser", bus.tuser_1st_out, tuser);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.segs_out_valid, 1'b1);
      check("hold_lo", bus.segs_out[511:0], exp_out[511:0]);
      check("hold_hi", bus.segs_out[1023:512], exp_out[1023:512]);
      check("hold_tuser", bus.tuser_1st_out, tuser);
      check("hold_rdy", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b000);
    end
    bus.segs_out_ready = 1'b1;
    @(negedge clk);
    bus.segs_out_ready = 1'b0;
    check("post_hs_valid", bus.segs_out_valid, 1'b0);
    check("post_hs_rdy", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b111);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1023:0] s, p;
    logic [159:0]  b;
    logic [127:0]  t;
    bus.phv_in = '0; bus.phv_in_valid = 1'b0;
    bus.segs_in = '0; bus.tuser_1st_in = '0; bus.segs_in_valid = 1'b0;
    bus.bram_in = '0; bus.bram_in_valid = 1'b0;
    bus.segs_out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rdy", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b000);
    check("rst_valid", bus.segs_out_valid, 1'b0);
    check("rst_err", bus.deparse_err, 1'b0);
    check("rst_segs_lo", bus.segs_out[511:0], 512'd0);
    check("rst_segs_hi", bus.segs_out[1023:512], 512'd0);
    check("rst_tuser", bus.tuser_1st_out, 128'd0);
    rst = 1'b0;
    #1;
    check("rel_rdy", {bus.segs_in_ready, bus.phv_in_ready, bus.bram_in_ready}, 3'b111);

    // Single 6B entry at offset 0
    p = 1024'h112233445566 << 976;
    b = 160'(mk_ent(1, 2, 0, 0, 0));
    run_packet('0, p, b, 128'hABCD, 0, 0, 0, 0, -1);
    check("single_ref", exp_out[511:0], 512'h665544332211);

    // Overlapping 2B entries, later wins
    p = (1024'hAAAA << 352) | (1024'hBBBB << 336);
    b = {128'd0, mk_ent(1, 0, 2, 11, 0), mk_ent(1, 0, 1, 10, 0)};
    run_packet('0, p, b, 128'h1, 0, 0, 0, 0, -1);

    // Rejects (4B past end, reserved type), exact-fit 6B, skipped invalid entry
    s = rand_wide(); p = rand_wide();
    b = {112'd0, mk_ent(0, 2, 3, 0, 0), mk_ent(1, 2, 7, 122, 5), mk_ent(1, 3, 0, 0, 0), mk_ent(1, 1, 0, 126, 0)};
    run_packet(s, p, b, 128'h2, 0, 0, 0, 0, -1);

    // Same data, simultaneous versus staggered arrival
    s = rand_wide(); p = rand_wide(); b = rand_bram(); t = 128'(rand_wide());
    run_packet(s, p, b, t, 0, 0, 0, 0, -1);
    run_packet(s, p, b, t, 0, 3, 8, 0, -1);

    // Long back-pressure
    run_packet(rand_wide(), rand_wide(), rand_bram(), 128'(rand_wide()), 1, 0, 2, 20, -1);

    // Reset in the middle of WRITE, then a clean packet
    run_packet(rand_wide(), rand_wide(), rand_bram(), 128'(rand_wide()), 0, 0, 0, 0, 5);
    run_packet(rand_wide(), rand_wide(), rand_bram(), 128'(rand_wide()), 2, 1, 0, 1, -1);

    // Random traffic
    for (int i = 0; i < 25; i++) begin
      run_packet(rand_wide(), rand_wide(), rand_bram(), 128'(rand_wide()),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
